// File: rtl/nn_weight_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nn_weight_scan_ctrl
//  Purpose  : Host-side load / non-destructive readback controller for the
//             neural-network weight scan chain.
//             Optional NN_SCAN_CHECKSUM_EN builds a running word-sum checksum.
//  Revision : 1.0  initial release
// ============================================================================
module nn_weight_scan_ctrl #(
   parameter int ChainLen = 7
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        cmd_valid_i,
   input  logic        cmd_op_i,
   output logic        cmd_ready_o,
   input  logic        wr_valid_i,
   input  logic [31:0] wr_data_i,
   output logic        wr_ready_o,
   output logic        rd_valid_o,
   output logic [31:0] rd_data_o,
   input  logic        rd_ready_i,
   output logic        shift_o,
   output logic [31:0] chain_weights_o,
   input  logic [31:0] chain_weights_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] checksum_o
);

   localparam int              CntW   = $clog2(ChainLen + 1);
   localparam logic [CntW-1:0] c_LAST = CntW'(ChainLen);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RD_CAP  = 3'd2,
      S_RD_WAIT = 3'd3,
      S_FINISH  = 3'd4
   } state_t;

   state_t          r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_shift;
   logic            r_rd_valid;
   logic            r_done;
   logic [31:0]     r_rd_data;
   logic [31:0]     r_chain_w;
   logic [CntW-1:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + CntW'(1);

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_shift    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_done     <= 1'b0;
         r_rd_data  <= '0;
         r_chain_w  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_shift <= 1'b0;
               if (cmd_valid_i) begin
                  r_cnt   <= '0;
                  r_state <= cmd_op_i ? S_RD_CAP : S_LOAD;
               end
            end
            S_LOAD: begin
               if (wr_valid_i) begin
                  r_chain_w <= wr_data_i;
                  r_shift   <= 1'b1;
                  r_cnt     <= w_cnt_inc;
                  if (w_cnt_inc == c_LAST) begin
                     r_state <= S_FINISH;
                  end
               end else begin
                  r_shift <= 1'b0;
               end
            end
            S_RD_CAP: begin
               // Tail word is both reported and fed back to stage 0
               r_rd_data  <= chain_weights_i;
               r_rd_valid <= 1'b1;
               r_chain_w  <= chain_weights_i;
               r_shift    <= 1'b1;
               r_cnt      <= w_cnt_inc;
               r_state    <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               r_shift <= 1'b0;
               if (r_rd_valid && rd_ready_i) begin
                  r_rd_valid <= 1'b0;
                  r_state    <= (r_cnt == c_LAST) ? S_FINISH : S_RD_CAP;
               end
            end
            S_FINISH: begin
               r_shift <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_shift <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o     = (r_state == S_IDLE);
   assign wr_ready_o      = (r_state == S_LOAD);
   assign busy_o          = (r_state != S_IDLE);
   assign rd_valid_o      = r_rd_valid;
   assign rd_data_o       = r_rd_data;
   assign shift_o         = r_shift;
   assign chain_weights_o = r_chain_w;
   assign done_o          = r_done;

`ifdef NN_SCAN_CHECKSUM_EN
   logic [31:0] r_checksum;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_checksum <= '0;
      end else if (r_state == S_IDLE && cmd_valid_i) begin
         r_checksum <= '0;
      end else if (r_state == S_LOAD && wr_valid_i) begin
         r_checksum <= r_checksum + wr_data_i;
      end else if (r_state == S_RD_CAP) begin
         r_checksum <= r_checksum + chain_weights_i;
      end
   end

   assign checksum_o = r_checksum;
`else
   assign checksum_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nn_weight_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nn_weight_scan_ctrl
//  Purpose  : Self-checking bench for nn_weight_scan_ctrl with a behavioural
//             scan chain and a readback scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nn_weight_scan_ctrl;

   localparam int CL = 7;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_op_i = 1'b0;
   logic        cmd_ready_o;
   logic        wr_valid_i = 1'b0;
   logic [31:0] wr_data_i = '0;
   logic        wr_ready_o;
   logic        rd_valid_o;
   logic [31:0] rd_data_o;
   logic        rd_ready_i = 1'b0;
   logic        shift_o;
   logic [31:0] chain_weights_o;
   logic [31:0] chain_weights_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] checksum_o;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] golden[CL];
   logic [31:0] chain[CL];
   logic        scribble = 1'b0;

   always #5 clk = ~clk;

   nn_weight_scan_ctrl #(.ChainLen(CL)) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .cmd_valid_i     (cmd_valid_i),
      .cmd_op_i        (cmd_op_i),
      .cmd_ready_o     (cmd_ready_o),
      .wr_valid_i      (wr_valid_i),
      .wr_data_i       (wr_data_i),
      .wr_ready_o      (wr_ready_o),
      .rd_valid_o      (rd_valid_o),
      .rd_data_o       (rd_data_o),
      .rd_ready_i      (rd_ready_i),
      .shift_o         (shift_o),
      .chain_weights_o (chain_weights_o),
      .chain_weights_i (chain_weights_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .checksum_o      (checksum_o)
   );

   // Behavioural network scan chain: stage 0 in, stage CL-1 is the tail
   always @(posedge clk) begin
      if (scribble) begin
         for (int i = 0; i < CL; i++) chain[i] <= 32'hBAD0_0000 | 32'(i);
      end else if (shift_o) begin
         for (int i = CL - 1; i > 0; i--) chain[i] <= chain[i-1];
         chain[0] <= chain_weights_o;
      end
   end
   assign chain_weights_i = chain[CL-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({shift_o, rd_valid_o, done_o} !== 3'b000) begin
         n_err++; $display("FAIL reset_flags: got %b want 000", {shift_o, rd_valid_o, done_o});
      end
      n_cmp++;
      if (rd_data_o !== 32'd0 || chain_weights_o !== 32'd0 || checksum_o !== 32'd0) begin
         n_err++; $display("FAIL reset_data: rd=%h chain=%h sum=%h want 0", rd_data_o, chain_weights_o, checksum_o);
      end
      n_cmp++;
      if ({cmd_ready_o, wr_ready_o, busy_o} !== 3'b100) begin
         n_err++; $display("FAIL reset_decode: got %b want 100", {cmd_ready_o, wr_ready_o, busy_o});
      end
      scribble = 1'b1;
      tick();
      scribble = 1'b0;
      reset_i = 1'b1;
      tick();
      n_cmp++;
      if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_err++; $display("FAIL idle_after_reset: ready=%b busy=%b want 1 0", cmd_ready_o, busy_o);
      end
   endtask

   task automatic check_chain(input string tag);
      for (int i = 0; i < CL; i++) begin
         n_cmp++;
         if (chain[i] !== golden[i]) begin
            n_err++; $display("FAIL %s stage%0d: got %h want %h", tag, i, chain[i], golden[i]);
         end
      end
   endtask

   task automatic test_load_b2b();
      logic [31:0] w;
      logic [31:0] sum;
      sum = '0;
      cmd_valid_i = 1'b1; cmd_op_i = 1'b0;
      tick();
      cmd_valid_i = 1'b0;
      n_cmp++;
      if (busy_o !== 1'b1 || wr_ready_o !== 1'b1) begin
         n_err++; $display("FAIL load_accept: busy=%b wr_ready=%b want 1 1", busy_o, wr_ready_o);
      end
      for (int i = 0; i < CL; i++) begin
         w = 32'(32'h11 * (i + 1));
         golden[CL-1-i] = w;
         sum += w;
         wr_valid_i = 1'b1; wr_data_i = w;
         tick();
         n_cmp++;
         if (shift_o !== 1'b1) begin
            n_err++; $display("FAIL load_shift word%0d: got %b want 1", i, shift_o);
         end
      end
      wr_valid_i = 1'b0;
      n_cmp++;
      if (done_o !== 1'b0 || wr_ready_o !== 1'b0) begin
         n_err++; $display("FAIL load_finish: done=%b wr_ready=%b want 0 0", done_o, wr_ready_o);
      end
      tick();
      n_cmp++;
      if ({done_o, cmd_ready_o, shift_o} !== 3'b110) begin
         n_err++; $display("FAIL load_done: done/ready/shift=%b want 110", {done_o, cmd_ready_o, shift_o});
      end
      tick();
      n_cmp++;
      if (done_o !== 1'b0) begin
         n_err++; $display("FAIL load_done_pulse: got %b want 0", done_o);
      end
      check_chain("load_b2b");
`ifdef NN_SCAN_CHECKSUM_EN
      w = sum;
`else
      w = 32'd0;
`endif
      n_cmp++;
      if (checksum_o !== w) begin
         n_err++; $display("FAIL load_checksum: got %h want %h", checksum_o, w);
      end
   endtask

   task automatic test_readback(input int stall_word, input int stall_cycles);
      logic [31:0] sum;
      logic [31:0] e;
      int          got_n;
      int          stall_left;
      int          shifts;
      int          cyc;
      sum = '0; got_n = 0; stall_left = stall_cycles; shifts = 0; cyc = 0;
      for (int i = 0; i < CL; i++) begin
         exp_q.push_back(golden[CL-1-i]);
         sum += golden[i];
      end
      wr_valid_i = 1'b1; wr_data_i = 32'hDEAD_BEEF;
      rd_ready_i = 1'b1;
      cmd_valid_i = 1'b1; cmd_op_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      while (got_n < CL && cyc < 200) begin
         if (shift_o === 1'b1) shifts++;
         if (rd_valid_o === 1'b1 && got_n == stall_word && stall_left > 0) begin
            rd_ready_i = 1'b0;
            stall_left--;
            n_cmp++;
            if (rd_data_o !== exp_q[0]) begin
               n_err++; $display("FAIL rd_stall_hold: got %h want %h", rd_data_o, exp_q[0]);
            end
         end else begin
            rd_ready_i = 1'b1;
         end
         if (rd_valid_o === 1'b1 && rd_ready_i) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rd_data_o !== e) begin
               n_err++; $display("FAIL rd_data word%0d: got %h want %h", got_n, rd_data_o, e);
            end
            n_cmp++;
            if (shifts != 1) begin
               n_err++; $display("FAIL rd_shift_count word%0d: got %0d want 1", got_n, shifts);
            end
            shifts = 0;
            got_n++;
         end
         tick();
         cyc++;
      end
      wr_valid_i = 1'b0;
      n_cmp++;
      if (got_n != CL) begin
         n_err++; $display("FAIL rd_timeout: got %0d words want %0d", got_n, CL);
         exp_q.delete();
      end
      n_cmp++;
      if (done_o !== 1'b0 || busy_o !== 1'b1) begin
         n_err++; $display("FAIL rd_finish: done=%b busy=%b want 0 1", done_o, busy_o);
      end
      tick();
      n_cmp++;
      if (done_o !== 1'b1 || cmd_ready_o !== 1'b1) begin
         n_err++; $display("FAIL rd_done: done=%b ready=%b want 1 1", done_o, cmd_ready_o);
      end
      tick();
      check_chain("rd_unchanged");
`ifdef NN_SCAN_CHECKSUM_EN
      e = sum;
`else
      e = 32'd0;
`endif
      n_cmp++;
      if (checksum_o !== e) begin
         n_err++; $display("FAIL rd_checksum: got %h want %h", checksum_o, e);
      end
   endtask

   task automatic test_load_toggle();
      scribble = 1'b1;
      tick();
      scribble = 1'b0;
      cmd_valid_i = 1'b1; cmd_op_i = 1'b0;
      tick();
      cmd_op_i = 1'b1;
      for (int c = 0; c < 14; c++) begin
         cmd_valid_i = (c < 12);
         wr_valid_i  = (c % 2 == 0);
         wr_data_i   = (c % 2 == 0) ? 32'(32'h11 * (c / 2 + 1)) : 32'hFFFF_FFFF;
         tick();
         n_cmp++;
         if (shift_o !== (c % 2 == 0)) begin
            n_err++; $display("FAIL toggle_shift c%0d: got %b want %b", c, shift_o, (c % 2 == 0));
         end
         n_cmp++;
         if (done_o !== (c == 13)) begin
            n_err++; $display("FAIL toggle_done c%0d: got %b want %b", c, done_o, (c == 13));
         end
      end
      wr_valid_i = 1'b0;
      cmd_valid_i = 1'b0;
      tick();
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_err++; $display("FAIL toggle_idle: busy=%b want 0", busy_o);
      end
      check_chain("load_toggle");
   endtask

   task automatic test_reset_mid();
      int done_seen;
      done_seen = 0;
      cmd_valid_i = 1'b1; cmd_op_i = 1'b0;
      tick();
      cmd_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_valid_i = 1'b1; wr_data_i = 32'hA0 + 32'(i + 1);
         tick();
      end
      wr_valid_i = 1'b0;
      reset_i = 1'b0;
      tick();
      n_cmp++;
      if ({shift_o, busy_o, cmd_ready_o, done_o} !== 4'b0010) begin
         n_err++; $display("FAIL mid_reset: shift/busy/ready/done=%b want 0010", {shift_o, busy_o, cmd_ready_o, done_o});
      end
      n_cmp++;
      if (chain_weights_o !== 32'd0 || rd_valid_o !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_regs: chain=%h rd_valid=%b want 0 0", chain_weights_o, rd_valid_o);
      end
      reset_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done_o === 1'b1 || shift_o === 1'b1) done_seen++;
      end
      n_cmp++;
      if (done_seen != 0) begin
         n_err++; $display("FAIL mid_reset_quiet: got %0d active cycles want 0", done_seen);
      end
      for (int i = 0; i < CL; i++) golden[i] = chain[i];
      test_readback(-1, 0);
   endtask

   initial begin
      test_reset();
      test_load_b2b();
      test_readback(-1, 0);
      test_readback(2, 5);
      test_load_toggle();
      test_readback(-1, 0);
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
